// File: rtl/keypad_pkg.sv
// Shared key codes, pin patterns, FSM/scan-result enums and the keypad key map.
// Optional auto-repeat is selected with KEYPAD_REPEAT_EN (see keypad_debouncer).
package keypad_pkg;

   localparam logic [3:0] KEY_ZERO      = 4'd0;
   localparam logic [3:0] KEY_ONE       = 4'd1;
   localparam logic [3:0] KEY_TWO       = 4'd2;
   localparam logic [3:0] KEY_THREE     = 4'd3;
   localparam logic [3:0] KEY_FOUR      = 4'd4;
   localparam logic [3:0] KEY_FIVE      = 4'd5;
   localparam logic [3:0] KEY_SIX       = 4'd6;
   localparam logic [3:0] KEY_SEVEN     = 4'd7;
   localparam logic [3:0] KEY_EIGHT     = 4'd8;
   localparam logic [3:0] KEY_NINE      = 4'd9;
   localparam logic [3:0] KEY_BACKSPACE = 4'd10;
   localparam logic [3:0] KEY_ENTER     = 4'd11;
   localparam logic [3:0] KEY_PAUSE     = 4'd12;
   localparam logic [3:0] KEY_SWITCH    = 4'd13;
   localparam logic [3:0] KEY_NO_KEY    = 4'd14;
   // Internal marker for C/D, which are decoded as if nothing were pressed.
   localparam logic [3:0] KEY_IGNORED   = 4'd15;

   localparam logic [3:0] COL_1 = 4'b0111;
   localparam logic [3:0] COL_2 = 4'b1011;
   localparam logic [3:0] COL_3 = 4'b1101;
   localparam logic [3:0] COL_4 = 4'b1110;
   localparam logic [3:0] ROW_1 = 4'b0111;
   localparam logic [3:0] ROW_2 = 4'b1011;
   localparam logic [3:0] ROW_3 = 4'b1101;
   localparam logic [3:0] ROW_4 = 4'b1110;

   typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_HELD} kp_state_e;
   typedef enum logic [1:0] {SCAN_EMPTY, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;

   function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
      logic [3:0] k;
      case ({col, row})
         4'h0: k = KEY_ONE;    4'h1: k = KEY_FOUR;   4'h2: k = KEY_SEVEN;   4'h3: k = KEY_BACKSPACE;
         4'h4: k = KEY_TWO;    4'h5: k = KEY_FIVE;   4'h6: k = KEY_EIGHT;   4'h7: k = KEY_ZERO;
         4'h8: k = KEY_THREE;  4'h9: k = KEY_SIX;    4'hA: k = KEY_NINE;    4'hB: k = KEY_ENTER;
         4'hC: k = KEY_PAUSE;  4'hD: k = KEY_SWITCH; default: k = KEY_IGNORED;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_if.sv
// Key-event bundle from the scanner to the CPU input/IO controller.
interface keypad_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   modport master (output key_valid, key_code, key_held);
   modport slave  (input  key_valid, key_code, key_held);
endinterface

// File: rtl/keypad_debouncer.sv
// Per-scan debounce/release FSM producing one-cycle key events.
// KEYPAD_REPEAT_EN adds auto-repeat while a key stays held (never for PAUSE/SWITCH).
module keypad_debouncer
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 2,
   parameter int unsigned RELEASE_SCANS  = 1,
   parameter int unsigned REPEAT_SCANS   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_done,
   input  scan_kind_e  scan_kind,
   input  logic [3:0]  scan_code,
   keypad_if.master    kif
);
   localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int unsigned RW = $clog2(RELEASE_SCANS + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS - 1);
   localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_SCANS - 1);

   kp_state_e     state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    code_q, code_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rel_q, rel_d;
   logic          valid_q, valid_d;
`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned PW = $clog2(REPEAT_SCANS + 1);
   localparam logic [PW-1:0] REP_LAST = PW'(REPEAT_SCANS - 1);
   logic [PW-1:0] rep_q, rep_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cand_q  <= '0;
         code_q  <= KEY_NO_KEY;
         cnt_q   <= '0;
         rel_q   <= '0;
         valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   // Release/repeat counters only live in HELD, so they start from zero on every entry.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      rel_d   = (state_q == ST_HELD) ? rel_q : '0;
      valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = (state_q == ST_HELD) ? rep_q : '0;
`endif
      if (scan_done) begin
         unique case (state_q)
            ST_IDLE: begin
               if (scan_kind == SCAN_SINGLE) begin
                  cand_d = scan_code;
                  cnt_d  = DW'(1);
                  if (DEBOUNCE_SCANS <= 1) begin
                     state_d = ST_HELD;
                     code_d  = scan_code;
                     valid_d = 1'b1;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (scan_kind == SCAN_SINGLE && scan_code == cand_q) begin
                  if (cnt_q == DEB_LAST) begin
                     state_d = ST_HELD;
                     code_d  = cand_q;
                     valid_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (scan_kind == SCAN_SINGLE) begin
                  cand_d = scan_code;
                  cnt_d  = DW'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               unique case (scan_kind)
                  SCAN_EMPTY: begin
                     if (rel_q == REL_LAST) state_d = ST_IDLE;
                     else                   rel_d   = rel_q + 1'b1;
                  end
                  SCAN_SINGLE: begin
                     rel_d = '0;
                     if (scan_code != cand_q) begin
                        state_d = ST_DEBOUNCE;
                        cand_d  = scan_code;
                        cnt_d   = DW'(1);
                     end
`ifdef KEYPAD_REPEAT_EN
                     else if (cand_q != KEY_PAUSE && cand_q != KEY_SWITCH) begin
                        if (rep_q == REP_LAST) begin
                           rep_d   = '0;
                           valid_d = 1'b1;
                        end else begin
                           rep_d = rep_q + 1'b1;
                        end
                     end
`endif
                  end
                  default: rel_d = '0;
               endcase
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      kif.key_valid = valid_q;
      kif.key_code  = code_q;
      kif.key_held  = (state_q == ST_HELD);
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scan, row synchroniser and per-scan decode feeding keypad_debouncer.
// Build with KEYPAD_REPEAT_EN defined to enable auto-repeat of held keys.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES    = 62500,
   parameter int unsigned DEBOUNCE_SCANS = 2,
   parameter int unsigned RELEASE_SCANS  = 1,
   parameter int unsigned REPEAT_SCANS   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   keypad_if.master   kif
);
   localparam int unsigned CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);

   logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [1:0]    col_q, col_d;
   logic [1:0]    acc_cnt_q, acc_cnt_d;
   logic [3:0]    acc_code_q, acc_code_d;

   logic          sample, scan_done;
   logic [2:0]    col_hits, total;
   logic [3:0]    col_code, key, scan_code;
   scan_kind_e    scan_kind;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1_q   <= '1;
         row_s2_q   <= '1;
         cyc_q      <= '0;
         col_q      <= '0;
         acc_cnt_q  <= '0;
         acc_code_q <= '0;
      end else begin
         row_s1_q   <= row_s1_d;
         row_s2_q   <= row_s2_d;
         cyc_q      <= cyc_d;
         col_q      <= col_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_code_q <= acc_code_d;
      end
   end

   // Key count per scan saturates at 2 (MULTI); only the code of a lone key is kept.
   always_comb begin
      row_s1_d = row_in;
      row_s2_d = row_s1_q;
      sample    = (cyc_q == CYC_LAST);
      scan_done = sample && (col_q == 2'd3);
      cyc_d     = sample ? '0 : cyc_q + 1'b1;
      col_d     = sample ? col_q + 2'd1 : col_q;

      col_hits = '0;
      col_code = '0;
      key      = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         if (!row_s2_q[3-r]) begin
            key = key_lookup(col_q, 2'(r));
            if (key != KEY_IGNORED) begin
               col_hits = col_hits + 3'd1;
               col_code = key;
            end
         end
      end
      total     = {1'b0, acc_cnt_q} + col_hits;
      scan_code = (acc_cnt_q != 2'd0) ? acc_code_q : col_code;
      if (total == 3'd0)      scan_kind = SCAN_EMPTY;
      else if (total == 3'd1) scan_kind = SCAN_SINGLE;
      else                    scan_kind = SCAN_MULTI;

      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      if (scan_done) begin
         acc_cnt_d  = '0;
         acc_code_d = '0;
      end else if (sample) begin
         acc_cnt_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
         acc_code_d = scan_code;
      end
   end

   always_comb begin
      unique case (col_q)
         2'd0:    col_out = COL_1;
         2'd1:    col_out = COL_2;
         2'd2:    col_out = COL_3;
         default: col_out = COL_4;
      endcase
   end

   keypad_debouncer #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .RELEASE_SCANS  (RELEASE_SCANS),
      .REPEAT_SCANS   (REPEAT_SCANS)
   ) u_debouncer (
      .clk       (clk),
      .rst       (rst),
      .scan_done (scan_done),
      .scan_kind (scan_kind),
      .scan_code (scan_code),
      .kif       (kif)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated key matrix, scan-level behavioural model, directed + random presses.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SC       = 8;
   localparam int SCAN_LEN = 4 * SC;
   localparam int DEB      = 2;
   localparam int REL      = 1;
   localparam int REP      = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   keypad_if   kif ();

   keypad_scanner #(
      .SCAN_CYCLES    (SC),
      .DEBOUNCE_SCANS (DEB),
      .RELEASE_SCANS  (REL),
      .REPEAT_SCANS   (REP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .row_in  (row_in),
      .col_out (col_out),
      .kif     (kif)
   );

   always #5 clk = ~clk;

   // pressed[col][row], 0-based; a pressed key shorts its row low while its column is driven low.
   bit pressed [4][4];
   int keymap  [4][4] = '{'{1, 4, 7, 10}, '{2, 5, 8, 0}, '{3, 6, 9, 11}, '{12, 13, -1, -1}};

   always_comb begin
      row_in = 4'b1111;
      for (int c = 0; c < 4; c++)
         if (col_out[3-c] == 1'b0)
            for (int r = 0; r < 4; r++)
               if (pressed[c][r]) row_in[3-r] = 1'b0;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: evaluates each complete scan of the key matrix.
   int   tick;
   int   streak_key, streak_len, rel_cnt, rep_cnt, held_key;
   bit   held;
   logic exp_valid, exp_held;
   logic [3:0] exp_code;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tick = 0; streak_key = 0; streak_len = 0; rel_cnt = 0; rep_cnt = 0;
         held = 0; held_key = 0;
         exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'd14;
      end else begin
         exp_valid = 1'b0;
         if (tick % SCAN_LEN == SCAN_LEN - 1) begin
            int n, k;
            n = 0; k = 0;
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  if (pressed[c][r] && keymap[c][r] >= 0) begin
                     n++;
                     k = keymap[c][r];
                  end
            if (held) begin
               if (n == 0) begin
                  rel_cnt++;
                  if (rel_cnt >= REL) begin held = 0; exp_held = 1'b0; end
               end else if (n > 1) begin
                  rel_cnt = 0;
               end else if (k == held_key) begin
                  rel_cnt = 0;
`ifdef KEYPAD_REPEAT_EN
                  if (k != 12 && k != 13) begin
                     rep_cnt++;
                     if (rep_cnt == REP) begin
                        rep_cnt = 0; exp_valid = 1'b1; exp_code = 4'(k);
                     end
                  end
`endif
               end else begin
                  held = 0; exp_held = 1'b0; streak_key = k; streak_len = 1;
               end
            end else if (n == 1) begin
               streak_len = (streak_len > 0 && k == streak_key) ? streak_len + 1 : 1;
               streak_key = k;
               if (streak_len >= DEB) begin
                  exp_valid = 1'b1; exp_code = 4'(k); exp_held = 1'b1;
                  held = 1; held_key = k; rel_cnt = 0; rep_cnt = 0; streak_len = 0;
               end
            end else begin
               streak_len = 0;
            end
         end
         tick = tick + 1;
      end
   end

   // Per-cycle comparison against the model, plus an event log for directed checks.
   int ev_codes[$];
   int ev_ticks[$];

   always @(negedge clk) begin
      if (!rst) begin
         logic [3:0] one = 4'b1000;
         check("col_out", int'(col_out), int'(4'b1111 ^ (one >> ((tick / SC) % 4))));
         check("key_valid", int'(kif.key_valid), int'(exp_valid));
         check("key_code", int'(kif.key_code), int'(exp_code));
         check("key_held", int'(kif.key_held), int'(exp_held));
         if (kif.key_valid) begin
            ev_codes.push_back(int'(kif.key_code));
            ev_ticks.push_back(tick);
         end
      end
   end

   task automatic wait_scans(input int n);
      repeat (n) begin
         @(negedge clk);
         while (tick % SCAN_LEN != 0) @(negedge clk);
      end
   endtask

   task automatic wait_tick(input int t);
      while (tick < t) @(negedge clk);
   endtask

   task automatic release_all();
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) pressed[c][r] = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"},   int'(col_out), 7);
      check({tag, "_code"},  int'(kif.key_code), 14);
      check({tag, "_valid"}, int'(kif.key_valid), 0);
      check({tag, "_held"},  int'(kif.key_held), 0);
   endtask

   initial begin
      int base;
      int seq_key[4] = '{0, 11, 3, 11};
      int seq_c[4]   = '{1, 2, 2, 2};
      int seq_r[4]   = '{3, 3, 0, 3};
      release_all();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      wait_tick(8);  check("col_step2", int'(col_out), 4'b1011);
      wait_tick(16); check("col_step3", int'(col_out), 4'b1101);
      wait_tick(24); check("col_step4", int'(col_out), 4'b1110);

      // "5" after one empty scan, held two scans.
      wait_scans(1);
      pressed[1][1] = 1;
      wait_scans(2);
      check("five_pulse_valid", int'(kif.key_valid), 1);
      check("five_pulse_held", int'(kif.key_held), 1);
      release_all();
      wait_scans(1);
      check("five_release_held", int'(kif.key_held), 0);
      check("five_event_count", ev_codes.size(), 1);
      if (ev_codes.size() >= 1) begin
         check("five_event_code", ev_codes[0], 5);
         check("five_event_tick", ev_ticks[0], 96);
      end

      // 0, #, 3, #: one event each.
      base = ev_codes.size();
      for (int i = 0; i < 4; i++) begin
         pressed[seq_c[i]][seq_r[i]] = 1;
         wait_scans(4);
         release_all();
         wait_scans(2);
      end
      check("seq_event_count", ev_codes.size() - base, 4);
      if (ev_codes.size() - base == 4)
         for (int i = 0; i < 4; i++) check("seq_event_code", ev_codes[base+i], seq_key[i]);

      // "1"+"2" together, then "2" released.
      base = ev_codes.size();
      pressed[0][0] = 1; pressed[1][0] = 1;
      wait_scans(3);
      check("multi_no_event", ev_codes.size() - base, 0);
      check("multi_not_held", int'(kif.key_held), 0);
      pressed[1][0] = 0;
      wait_scans(3);
      check("multi_then_one_count", ev_codes.size() - base, 1);
      if (ev_codes.size() - base == 1) check("multi_then_one_code", ev_codes[base], 1);
      release_all();
      wait_scans(2);

      // "7" for one scan, then reset while still debouncing.
      base = ev_codes.size();
      pressed[0][2] = 1;
      wait_scans(1);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      release_all();
      rst = 1'b0;
      wait_scans(3);
      check("midrst_no_event", ev_codes.size() - base, 0);
      check("midrst_code_kept", int'(kif.key_code), 14);

      // Long holds: "9" and "A".
      base = ev_codes.size();
      pressed[2][2] = 1;
      wait_scans(20);
      release_all();
      wait_scans(2);
`ifdef KEYPAD_REPEAT_EN
      check("nine_event_count", ev_codes.size() - base, 3);
`else
      check("nine_event_count", ev_codes.size() - base, 1);
`endif
      if (ev_codes.size() > base) check("nine_event_code", ev_codes[base], 9);
      base = ev_codes.size();
      pressed[3][0] = 1;
      wait_scans(20);
      release_all();
      wait_scans(2);
      check("pause_event_count", ev_codes.size() - base, 1);
      if (ev_codes.size() > base) check("pause_event_code", ev_codes[base], 12);

      // Random key patterns, changed only at scan boundaries.
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 1) == 0) begin
            int sel;
            release_all();
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
            end else if (sel < 7) begin
               pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1;
            end else begin
               pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1;
               pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1;
            end
         end
         wait_scans($urandom_range(1, 3));
      end
      release_all();
      wait_scans(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
